i2c_reg_access_ctrl: RTL
========================

Name: i2c_reg_access_ctrl

Overview:
Register-access sequencer that sits in front of i2c_master. It converts one register read or write request into the i2c_master command and data AXI-stream transactions. A write performs START, addr+W, reg, data, STOP. A read performs START, addr+W, reg, then repeated START, addr+R, one data byte, STOP. It reports completion with read data, NACK error and timeout status, so that firmware or upper logic never drives i2c_master directly.

Parameters:
REG_ADDR_BYTES, 1, register address width in bytes (1 or 2); sent MSB first.
TIMEOUT_CYCLES, 65535, maximum clk cycles spent in any single non-idle state before abort.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when both high
req_read  in  1  1=read, 0=write
req_dev_addr  in  7  I2C device address
req_reg_addr  in  8*REG_ADDR_BYTES  register address
req_wdata  in  8  write data
resp_valid  out  1  response valid, held until resp_ready
resp_ready  in  1  response accepted
resp_rdata  out  8  read data (0 on write or error)
resp_error  out  1  NACK seen or timeout
resp_timeout  out  1  timeout abort
m_cmd_address  out  7  to i2c_master s_axis_cmd_address
m_cmd_start / m_cmd_read / m_cmd_write / m_cmd_write_multiple / m_cmd_stop  out  1 each  command flags
m_cmd_valid  out  1  command valid
m_cmd_ready  in  1  command ready
m_data_tdata  out  8  to master s_axis_data
m_data_tvalid  out  1
m_data_tready  in  1
m_data_tlast  out  1
s_data_tdata  in  8  from master m_axis_data
s_data_tvalid  in  1
s_data_tready  out  1
m_busy  in  1  i2c_master busy
m_missed_ack  in  1  i2c_master missed_ack

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0 except req_ready=1. Sticky flags cleared. A reset mid-transaction drops every valid on the next edge. The master is reset separately.
- All outputs are registered. req_ready=1 only in IDLE. On req_valid&&req_ready the request is captured into registers. Next cycle is CMD1 and req_ready=0.
- CMD1: m_cmd_valid=1, address=dev, start=1.
  - Write request: write_multiple=1, stop=1.
  - Read request: write_multiple=1, stop=0.
  - Leave CMD1 on m_cmd_valid&&m_cmd_ready; valid drops the same edge.
- REG: present register-address bytes MSB first, each held until m_data_tvalid&&m_data_tready.
  - tlast is set on the last reg byte for a read.
  - For a write, tlast is set only on the data byte.
- WDATA (write only): tdata=wdata, tlast=1, then go to WAIT_IDLE.
- CMD2 (read only): start=1, read=1, stop=1, then go to RDATA.
- RDATA: s_data_tready=1. On s_data_tvalid the byte is captured into rdata, then go to WAIT_IDLE.
- WAIT_IDLE: wait for m_busy==0 sampled for 2 consecutive cycles, then go to DONE.
- DONE: resp_valid=1. Leave on resp_ready and return to IDLE the next cycle. Back-to-back requests are accepted from IDLE with a single idle cycle of gap.
- Error flag: set on any cycle with m_missed_ack=1 between acceptance and DONE. It does not abort; the sequence completes so the master is never left stalled. In DONE, resp_error = flag|timeout. resp_rdata is forced to 0 when resp_error=1 or for a write.
- Timeout: a cycle counter is cleared on every state transition and increments in CMD1, REG, WDATA, CMD2, RDATA and WAIT_IDLE.
  - At TIMEOUT_CYCLES, drop all m_*valid and s_data_tready, go to DONE with resp_error=1 and resp_timeout=1.
  - Timeout takes priority over a handshake completing in the same cycle.
- The counter is 16 bits wide and saturates; it does not wrap.
- m_cmd_* and m_data_* are stable while valid is high and not yet accepted (AXI-stream rule).

Test Plan:
1. REG_ADDR_BYTES=1, write dev 0x42 reg 0x10 data 0xAA, i2c_slave model acks -> exactly one cmd (start, write_multiple, stop); data bytes 0x10 then 0xAA with tlast on 0xAA; resp_valid with error=0, rdata=0x00.
2. Read dev 0x42 reg 0x10, slave returns 0xCC -> cmd1 has stop=0, byte 0x10 with tlast, cmd2 (start, read, stop); resp_rdata=0xCC, error=0.
3. Write to absent dev 0x01 (bus NACK, m_missed_ack pulse) -> sequence still completes; resp_error=1, resp_timeout=0, rdata=0.
4. TIMEOUT_CYCLES=100, m_cmd_ready held 0 -> after 100 cycles m_cmd_valid=0; resp_error=1, resp_timeout=1; next request accepted.
5. REG_ADDR_BYTES=2, read reg 0x1234 -> bytes 0x12, 0x34 (tlast on 0x34); data returned correctly. Two back-to-back requests with resp_ready tied 1 both complete in order.
6. rst_n=0 asserted during REG with tvalid=1 -> next edge all valids 0, req_ready=1, resp_valid=0.

Source files
------------

// File: rtl/i2c_reg_access_ctrl_if.sv
// Request/response port plus i2c_master cmd/data streams of the register sequencer.
// slave = sequencer view, master = surrounding logic / i2c_master view.
interface i2c_reg_access_ctrl_if #(
  parameter int REG_ADDR_BYTES = 1
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_read;
  logic [6:0]                  req_dev_addr;
  logic [8*REG_ADDR_BYTES-1:0] req_reg_addr;
  logic [7:0]                  req_wdata;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [7:0]                  resp_rdata;
  logic                        resp_error;
  logic                        resp_timeout;
  logic [6:0]                  m_cmd_address;
  logic                        m_cmd_start;
  logic                        m_cmd_read;
  logic                        m_cmd_write;
  logic                        m_cmd_write_multiple;
  logic                        m_cmd_stop;
  logic                        m_cmd_valid;
  logic                        m_cmd_ready;
  logic [7:0]                  m_data_tdata;
  logic                        m_data_tvalid;
  logic                        m_data_tready;
  logic                        m_data_tlast;
  logic [7:0]                  s_data_tdata;
  logic                        s_data_tvalid;
  logic                        s_data_tready;
  logic                        m_busy;
  logic                        m_missed_ack;

  modport slave (
    input  req_valid, req_read, req_dev_addr,
    input  req_reg_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata,
    output resp_error, resp_timeout,
    output m_cmd_address, m_cmd_start, m_cmd_read,
    output m_cmd_write, m_cmd_write_multiple,
    output m_cmd_stop, m_cmd_valid,
    input  m_cmd_ready,
    output m_data_tdata, m_data_tvalid, m_data_tlast,
    input  m_data_tready,
    input  s_data_tdata, s_data_tvalid,
    output s_data_tready,
    input  m_busy, m_missed_ack
  );

  modport master (
    output req_valid, req_read, req_dev_addr,
    output req_reg_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_error, resp_timeout,
    input  m_cmd_address, m_cmd_start, m_cmd_read,
    input  m_cmd_write, m_cmd_write_multiple,
    input  m_cmd_stop, m_cmd_valid,
    output m_cmd_ready,
    input  m_data_tdata, m_data_tvalid, m_data_tlast,
    output m_data_tready,
    output s_data_tdata, s_data_tvalid,
    input  s_data_tready,
    output m_busy, m_missed_ack
  );
endinterface

// File: rtl/i2c_reg_access_ctrl.sv
// Turns one register read/write request into i2c_master cmd/data stream
// transactions and reports read data, NACK and timeout status.
module i2c_reg_access_ctrl #(
  parameter int REG_ADDR_BYTES = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic clk,
  input logic rst_n,
  i2c_reg_access_ctrl_if.slave bus
);
  localparam int RW = 8 * REG_ADDR_BYTES;
  localparam int IW = (REG_ADDR_BYTES > 1) ? $clog2(REG_ADDR_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(REG_ADDR_BYTES - 1);
  localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD1, REG, WDATA, CMD2, RDATA, WAIT_IDLE, DONE
  } state_t;

  typedef struct packed {
    logic       req_ready;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_error;
    logic       resp_timeout;
    logic [6:0] cmd_address;
    logic       cmd_start;
    logic       cmd_read;
    logic       cmd_write;
    logic       cmd_wm;
    logic       cmd_stop;
    logic       cmd_valid;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       s_tready;
  } out_t;

  localparam out_t OUT_RST = '{req_ready: 1'b1, default: '0};

  state_t state, state_n;
  out_t o, o_n;
  logic rd, rd_n;
  logic [6:0] dev, dev_n;
  logic [RW-1:0] rega, rega_n, sh;
  logic [7:0] wd, wd_n, rdat, rdat_n;
  logic [IW-1:0] idx, idx_n;
  logic [15:0] cnt, cnt_n;
  logic err, err_n, tmo, tmo_n, fail;
  logic idle_seen, idle_seen_n;
  logic active, expired, cmd_hs, dat_hs, rx_hs;

  assign active = state inside {CMD1, REG, WDATA, CMD2, RDATA, WAIT_IDLE};
  assign expired = active && (cnt >= TLIM);
  assign cmd_hs = o.cmd_valid && bus.m_cmd_ready;
  assign dat_hs = o.tvalid && bus.m_data_tready;
  assign rx_hs = o.s_tready && bus.s_data_tvalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      o <= OUT_RST;
      rd <= 1'b0;
      dev <= '0;
      rega <= '0;
      wd <= '0;
      rdat <= '0;
      idx <= '0;
      cnt <= '0;
      err <= 1'b0;
      tmo <= 1'b0;
      idle_seen <= 1'b0;
    end else begin
      state <= state_n;
      o <= o_n;
      rd <= rd_n;
      dev <= dev_n;
      rega <= rega_n;
      wd <= wd_n;
      rdat <= rdat_n;
      idx <= idx_n;
      cnt <= cnt_n;
      err <= err_n;
      tmo <= tmo_n;
      idle_seen <= idle_seen_n;
    end
  end

  always_comb begin
    state_n = state;
    rd_n = rd;
    dev_n = dev;
    rega_n = rega;
    wd_n = wd;
    rdat_n = rdat;
    idx_n = idx;
    idle_seen_n = idle_seen;
    err_n = err | (active & bus.m_missed_ack);
    tmo_n = tmo;
    cnt_n = cnt;
    // Timeout wins over any handshake finishing in the same cycle
    if (expired) begin
      state_n = DONE;
      tmo_n = 1'b1;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid && o.req_ready) begin
          state_n = CMD1;
          rd_n = bus.req_read;
          dev_n = bus.req_dev_addr;
          rega_n = bus.req_reg_addr;
          wd_n = bus.req_wdata;
          rdat_n = '0;
          idx_n = '0;
          err_n = 1'b0;
          tmo_n = 1'b0;
        end
        CMD1: if (cmd_hs) state_n = REG;
        REG: if (dat_hs) begin
          if (idx == LAST) state_n = rd ? CMD2 : WDATA;
          else idx_n = idx + 1'b1;
        end
        WDATA: if (dat_hs) state_n = WAIT_IDLE;
        CMD2: if (cmd_hs) state_n = RDATA;
        RDATA: if (rx_hs) begin
          rdat_n = bus.s_data_tdata;
          state_n = WAIT_IDLE;
        end
        WAIT_IDLE: begin
          idle_seen_n = !bus.m_busy;
          if (idle_seen && !bus.m_busy) state_n = DONE;
        end
        DONE: if (o.resp_valid && bus.resp_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    if (state_n != state) begin
      cnt_n = '0;
      idle_seen_n = 1'b0;
    end else if (active && cnt != 16'hFFFF) begin
      cnt_n = cnt + 16'd1;
    end
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it
  always_comb begin
    o_n = '0;
    fail = err_n | tmo_n;
    sh = rega_n << (8 * idx_n);
    unique case (state_n)
      IDLE: o_n.req_ready = 1'b1;
      CMD1: begin
        o_n.cmd_valid = 1'b1;
        o_n.cmd_address = dev_n;
        o_n.cmd_start = 1'b1;
        o_n.cmd_wm = 1'b1;
        o_n.cmd_stop = !rd_n;
      end
      REG: begin
        o_n.tvalid = 1'b1;
        o_n.tdata = sh[RW-1 -: 8];
        o_n.tlast = rd_n && (idx_n == LAST);
      end
      WDATA: begin
        o_n.tvalid = 1'b1;
        o_n.tdata = wd_n;
        o_n.tlast = 1'b1;
      end
      CMD2: begin
        o_n.cmd_valid = 1'b1;
        o_n.cmd_address = dev_n;
        o_n.cmd_start = 1'b1;
        o_n.cmd_read = 1'b1;
        o_n.cmd_stop = 1'b1;
      end
      RDATA: o_n.s_tready = 1'b1;
      DONE: begin
        o_n.resp_valid = 1'b1;
        o_n.resp_error = fail;
        o_n.resp_timeout = tmo_n;
        o_n.resp_rdata = (fail || !rd_n) ? 8'h00 : rdat_n;
      end
      default: o_n = '0;
    endcase
  end

  assign bus.req_ready = o.req_ready;
  assign bus.resp_valid = o.resp_valid;
  assign bus.resp_rdata = o.resp_rdata;
  assign bus.resp_error = o.resp_error;
  assign bus.resp_timeout = o.resp_timeout;
  assign bus.m_cmd_address = o.cmd_address;
  assign bus.m_cmd_start = o.cmd_start;
  assign bus.m_cmd_read = o.cmd_read;
  assign bus.m_cmd_write = o.cmd_write;
  assign bus.m_cmd_write_multiple = o.cmd_wm;
  assign bus.m_cmd_stop = o.cmd_stop;
  assign bus.m_cmd_valid = o.cmd_valid;
  assign bus.m_data_tdata = o.tdata;
  assign bus.m_data_tvalid = o.tvalid;
  assign bus.m_data_tlast = o.tlast;
  assign bus.s_data_tready = o.s_tready;
endmodule
